// File: rtl/alu_op_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer_if
//   Request/response bus between an ALU client and alu_op_sequencer.
//   The request side carries one ALU operation: FunSel, operands, the
//   flag-write enable and the forward-A select. The response side returns the
//   captured result and flags and holds them until the client takes them.
//
//   Signals
//     req_valid    client -> seq   request present
//     req_ready    seq -> client   sequencer can accept a request
//     req_fun_sel  client -> seq   [4]=width (1:32-bit, 0:16-bit), [3:0]=op code
//     req_a        client -> seq   operand A
//     req_b        client -> seq   operand B
//     req_wf       client -> seq   1: this op writes the ALU flags
//     req_fwd_a    client -> seq   use the previous result as A (forwarding builds only)
//     rsp_valid    seq -> client   response valid
//     rsp_ready    client -> seq   client takes the response
//     rsp_data     seq -> client   captured result
//     rsp_flags    seq -> client   ALU flags {Z,C,N,O} after the op
//
//   Modports: master = client side, slave = sequencer side.
// ----------------------------------------------------------------------------
interface alu_op_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int FLAG_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        req_fun_sel;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic              req_wf;
    logic              req_fwd_a;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [FLAG_W-1:0] rsp_flags;

    modport master (
        output req_valid, req_fun_sel, req_a, req_b, req_wf, req_fwd_a, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_flags
    );

    modport slave (
        input  req_valid, req_fun_sel, req_a, req_b, req_wf, req_fwd_a, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_flags
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer
//   Control stage in front of the 32-bit ALU. Accepts one operation over a
//   valid/ready request, presents it to the ALU for exactly one cycle (the only
//   cycle in which ALU_WF may be high), captures the result at the end of that
//   cycle, captures the registered ALU flags one cycle later, and returns both
//   on a held valid/ready response.
//
//   FSM: IDLE -> EXEC -> FLAG -> RESP -> IDLE
//     IDLE : req_ready=1, request registered on accept
//     EXEC : ALU ports show the request, ALU_WF = latched WF; result captured
//     FLAG : ALU_WF=0, ALU flags (written at the end of EXEC) captured
//     RESP : rsp_valid=1 until rsp_ready
//
//   Ports
//     clk            rising-edge clock shared with the ALU
//     rst_n          asynchronous active-low reset
//     bus            alu_op_sequencer_if.slave request/response bus
//     alu_a_o        ALU operand A
//     alu_b_o        ALU operand B
//     alu_fun_sel_o  ALU FunSel (passed through unmodified)
//     alu_wf_o       ALU flag-write enable
//     alu_out_i      ALU result
//     alu_flags_i    ALU registered flags {Z,C,N,O}
//
//   Build option
//     ALU_SEQ_FWD_EN : when defined, req_fwd_a=1 at accept takes operand A
//                      from the current rsp_data register (previous result,
//                      0 after reset). When undefined req_fwd_a is ignored.
// ----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int DATA_W = 32,
    parameter int FLAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op_sequencer_if.slave  bus,
    output logic [DATA_W-1:0]  alu_a_o,
    output logic [DATA_W-1:0]  alu_b_o,
    output logic [4:0]         alu_fun_sel_o,
    output logic               alu_wf_o,
    input  logic [DATA_W-1:0]  alu_out_i,
    input  logic [FLAG_W-1:0]  alu_flags_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_FLAG = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t             state_q, state_d;

    logic [DATA_W-1:0]  alu_a_q;
    logic [DATA_W-1:0]  alu_b_q;
    logic [4:0]         alu_fun_sel_q;
    logic               wf_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic [FLAG_W-1:0]  rsp_flags_q;

    logic               req_ready;
    logic               rsp_valid;
    logic               alu_wf;
    logic               accept;

    logic [DATA_W-1:0]  a_src;
    logic [DATA_W-1:0]  a_ext;
    logic [DATA_W-1:0]  b_ext;
    logic [DATA_W-1:0]  res_ext;

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
`ifdef ALU_SEQ_FWD_EN
    // rsp_data_q still holds the previous result while in IDLE.
    assign a_src = bus.req_fwd_a ? rsp_data_q : bus.req_a;
`else
    logic unused_fwd_a;
    assign unused_fwd_a = bus.req_fwd_a;
    assign a_src        = bus.req_a;
`endif

    // 16-bit ops see sign-extended low halves; the selected A (possibly the
    // forwarded result) is extended the same way.
    assign a_ext = bus.req_fun_sel[4] ? a_src
                 : {{(DATA_W-16){a_src[15]}}, a_src[15:0]};
    assign b_ext = bus.req_fun_sel[4] ? bus.req_b
                 : {{(DATA_W-16){bus.req_b[15]}}, bus.req_b[15:0]};

    assign res_ext = alu_fun_sel_q[4] ? alu_out_i
                   : {{(DATA_W-16){alu_out_i[15]}}, alu_out_i[15:0]};

    assign accept = bus.req_valid & req_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_wf    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Held low while reset is asserted even though the state
                // register already reads IDLE.
                req_ready = rst_n;
                if (bus.req_valid && rst_n) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Decoded straight from the async-reset state register, so a
                // reset pulse drops the flag write without waiting for a clock.
                alu_wf  = wf_q;
                state_d = ST_FLAG;
            end
            ST_FLAG: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_fun_sel_q <= '0;
            wf_q          <= 1'b0;
            rsp_data_q    <= '0;
            rsp_flags_q   <= '0;
        end else begin
            if (state_q == ST_IDLE && accept) begin
                alu_a_q       <= a_ext;
                alu_b_q       <= b_ext;
                alu_fun_sel_q <= bus.req_fun_sel;
                wf_q          <= bus.req_wf;
            end
            if (state_q == ST_EXEC) begin
                rsp_data_q <= res_ext;
            end
            // The ALU updates its flags on the edge closing EXEC, so they are
            // only valid to sample on the edge closing FLAG.
            if (state_q == ST_FLAG) begin
                rsp_flags_q <= alu_flags_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign alu_a_o       = alu_a_q;
    assign alu_b_o       = alu_b_q;
    assign alu_fun_sel_o = alu_fun_sel_q;
    assign alu_wf_o      = alu_wf;

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_flags = rsp_flags_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
`timescale 1ns/1ps
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_fun_sel;
    logic        alu_wf;
    logic [31:0] alu_out;
    logic [35:0] alu_res;
    logic [3:0]  alu_flags_reg = 4'b0000;

    alu_op_sequencer_if bus ();

    alu_op_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .alu_a_o       (alu_a),
        .alu_b_o       (alu_b),
        .alu_fun_sel_o (alu_fun_sel),
        .alu_wf_o      (alu_wf),
        .alu_out_i     (alu_out),
        .alu_flags_i   (alu_flags_reg)
    );

`ifdef ALU_SEQ_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    // Behavioural ALU: returns {Z,C,N,O, result}
    function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] fs);
        logic [32:0] w;
        logic [31:0] r;
        logic        c;
        logic        o;
        w = '0;
        c = 1'b0;
        o = 1'b0;
        case (fs[3:0])
            4'd0:  r = a;
            4'd1:  r = b;
            4'd2:  r = ~a;
            4'd3:  r = ~b;
            4'd4:  begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                         o = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd6:  begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = w[32];
                         o = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd7:  r = a & b;
            4'd8:  r = a | b;
            4'd9:  r = a ^ b;
            4'd10: begin r = a << 1; c = a[31]; end
            4'd11: begin r = a >> 1; c = a[0]; end
            default: r = a + b;
        endcase
        return {(r == 32'd0), c, r[31], o, r};
    endfunction

    function automatic logic [31:0] sext16(input logic [31:0] v);
        return {{16{v[15]}}, v[15:0]};
    endfunction

    assign alu_res = alu_fn(alu_a, alu_b, alu_fun_sel);
    assign alu_out = alu_res[31:0];
    always @(posedge clk) if (alu_wf) alu_flags_reg <= alu_res[35:32];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and reference state
    typedef struct {
        logic [31:0] data;
        logic [3:0]  flags;
        logic        wf;
        int          acc;
        string       name;
    } exp_t;
    exp_t sb[$];

    logic [31:0] m_last  = 32'd0;   // previous result (forwarding source)
    logic [3:0]  m_flags = 4'd0;    // ALU flag register as the model sees it

    int checks   = 0;
    int failures = 0;
    int txn      = 0;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive a request, wait for accept, push expected result. Returns 1ns
    // after the accept edge, i.e. inside the EXEC cycle.
    task automatic issue(input string name, input logic [4:0] fs, input logic [31:0] a,
                         input logic [31:0] b, input logic wf, input logic fwd);
        exp_t        e;
        logic [31:0] a_src;
        logic [31:0] a_use;
        logic [31:0] b_use;
        logic [35:0] res;
        int          n;
        bus.req_fun_sel = fs;
        bus.req_a       = a;
        bus.req_b       = b;
        bus.req_wf      = wf;
        bus.req_fwd_a   = fwd;
        bus.req_valid   = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_req_ready"}, bus.req_ready, 1);
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        a_src  = (FWD_EN && fwd) ? m_last : a;
        a_use  = fs[4] ? a_src : sext16(a_src);
        b_use  = fs[4] ? b : sext16(b);
        res    = alu_fn(a_use, b_use, fs);
        e.data = fs[4] ? res[31:0] : sext16(res[31:0]);
        if (wf) m_flags = res[35:32];
        e.flags = m_flags;
        e.wf    = wf;
        e.acc   = cyc;
        e.name  = name;
        m_last  = e.data;
        sb.push_back(e);
        check({name, "_busy"}, bus.req_ready, 0);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drain"}, sb.size(), 0);
    endtask

    // Response monitor: samples on the falling edge
    initial begin : monitor
        logic prev_v;
        int   wf_cnt;
        exp_t e;
        prev_v = 1'b0;
        wf_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
                wf_cnt = 0;
            end else begin
                if (alu_wf) wf_cnt++;
                if (bus.rsp_valid && !prev_v) begin
                    if (sb.size() == 0)
                        check("unexpected_rsp", bus.rsp_valid, 0);
                    else
                        // accept edge, EXEC, FLAG, then RESP: two edges later
                        check({sb[0].name, "_latency"}, cyc - sb[0].acc, 2);
                end
                if (bus.rsp_valid && bus.rsp_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    check({e.name, "_data"}, bus.rsp_data, e.data);
                    check({e.name, "_flags"}, bus.rsp_flags, e.flags);
                    check({e.name, "_wf_pulses"}, wf_cnt, e.wf);
                    $display("txn %0d %s data=%h flags=%b wf_pulses=%0d", txn, e.name,
                             bus.rsp_data, bus.rsp_flags, wf_cnt);
                    txn++;
                    wf_cnt = 0;
                end
                prev_v = bus.rsp_valid;
            end
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk); #1;
            if (rand_ready) bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] d0;
        logic [3:0]  f0;
        logic [3:0]  saved_flags;
        int          n;
        rst_n           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_fun_sel = '0;
        bus.req_a       = '0;
        bus.req_b       = '0;
        bus.req_wf      = 1'b0;
        bus.req_fwd_a   = 1'b0;
        bus.rsp_ready   = 1'b1;

        #3;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_alu_wf", alu_wf, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_fun_sel", alu_fun_sel, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_flags", bus.rsp_flags, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rel_req_ready", bus.req_ready, 1);

        // ADD32 with carry out to zero
        issue("add32", 5'b10100, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
        drain("add32");
        check("add32_rsp_data", bus.rsp_data, 32'h0);
        check("add32_rsp_flags", bus.rsp_flags, 4'b1100);

        // Pass B without flag write: flags must be left alone
        issue("passb_nowf", 5'b10001, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
        drain("passb_nowf");
        check("passb_rsp_data", bus.rsp_data, 32'h8000_0000);
        check("passb_rsp_flags", bus.rsp_flags, 4'b1100);

        // 16-bit add: operands sign-extended
        issue("add16", 5'b00100, 32'h1234_8000, 32'd1, 1'b1, 1'b0);
        check("add16_alu_a", alu_a, 32'hFFFF_8000);
        check("add16_alu_wf", alu_wf, 1);
        drain("add16");
        check("add16_rsp_data", bus.rsp_data, 32'hFFFF_8001);

        // Back-pressure
        rand_ready    = 1'b0;
        bus.rsp_ready = 1'b0;
        issue("bp", 5'b10110, 32'd100, 32'd30, 1'b1, 1'b0);
        n = 0;
        while (!bus.rsp_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_valid", bus.rsp_valid, 1);
        d0 = bus.rsp_data;
        f0 = bus.rsp_flags;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", bus.rsp_valid, 1);
            check("bp_hold_data", bus.rsp_data, d0);
            check("bp_hold_flags", bus.rsp_flags, f0);
            check("bp_req_ready", bus.req_ready, 0);
            check("bp_alu_wf", alu_wf, 0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_ready_after", bus.req_ready, 1);
        check("bp_taken", sb.size(), 0);

        // Reset pulse during EXEC drops the op
        saved_flags = m_flags;
        issue("rst_exec", 5'b10100, 32'd7, 32'd9, 1'b1, 1'b0);
        check("rst_exec_wf_before", alu_wf, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_exec_wf", alu_wf, 0);
        check("rst_exec_valid", bus.rsp_valid, 0);
        check("rst_exec_ready", bus.req_ready, 0);
        void'(sb.pop_back());
        m_flags = saved_flags;
        m_last  = 32'd0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rst_exec_ready_after", bus.req_ready, 1);
        check("rst_exec_data_cleared", bus.rsp_data, 0);
        issue("post_rst", 5'b10100, 32'd11, 32'd22, 1'b1, 1'b0);
        drain("post_rst");

`ifdef ALU_SEQ_FWD_EN
        issue("fwd_op1", 5'b10100, 32'd5, 32'd3, 1'b1, 1'b0);
        drain("fwd_op1");
        issue("fwd_op2", 5'b10110, 32'hDEAD_BEEF, 32'd2, 1'b1, 1'b1);
        drain("fwd_op2");
        check("fwd_rsp_data", bus.rsp_data, 32'd6);
`endif

        // Randomized traffic with random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            issue("rnd", 5'($urandom), ra, rb, 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rand_ready    = 1'b0;
        bus.rsp_ready = 1'b1;
        drain("rnd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
